// File: rtl/fx2lp_pkg.sv
// Shared types, endpoint constants and the beat-count helper for the FX2LP stream writer.
package fx2lp_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, PKTEND} state_t;

  localparam logic [1:0] EP2 = 2'b00;
  localparam logic [1:0] EP4 = 2'b01;
  localparam logic [1:0] EP6 = 2'b10;
  localparam logic [1:0] EP8 = 2'b11;

  function automatic int beats(input int in_bytes, input int fd_width);
    return (in_bytes * 8) / fd_width;
  endfunction

endpackage

// File: rtl/fx2lp_stream_tx_if.sv
// Avalon-ST sink plus FX2LP slave-FIFO pins; slave = the writer, master = stream source / FX2LP side.
interface fx2lp_stream_tx_if #(
  parameter int IN_BYTES = 4,
  parameter int FD_WIDTH = 8
);
  logic [8*IN_BYTES-1:0] asi_in0_data;
  logic                  asi_in0_valid;
  logic                  asi_in0_ready;
  logic [FD_WIDTH-1:0]   coe_fx2lp_fd;
  logic                  coe_fx2lp_slrd_n;
  logic                  coe_fx2lp_slwr_n;
  logic                  coe_fx2lp_flagb_n;
  logic                  coe_fx2lp_sloe_n;
  logic [1:0]            coe_fx2lp_fifoadr;
  logic                  coe_fx2lp_pktend_n;

  modport slave (
    input  asi_in0_data, asi_in0_valid, coe_fx2lp_flagb_n,
    output asi_in0_ready, coe_fx2lp_fd, coe_fx2lp_slrd_n, coe_fx2lp_slwr_n,
           coe_fx2lp_sloe_n, coe_fx2lp_fifoadr, coe_fx2lp_pktend_n
  );

  modport master (
    output asi_in0_data, asi_in0_valid, coe_fx2lp_flagb_n,
    input  asi_in0_ready, coe_fx2lp_fd, coe_fx2lp_slrd_n, coe_fx2lp_slwr_n,
           coe_fx2lp_sloe_n, coe_fx2lp_fifoadr, coe_fx2lp_pktend_n
  );

endinterface

// File: rtl/fx2lp_pkt_timer.sv
// Packet byte counter and idle timer; commit_req asks for a PKTEND when a partial packet sits idle too long.
module fx2lp_pkt_timer #(
  parameter int FD_WIDTH     = 8,
  parameter int PKT_BYTES    = 512,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic in_idle,
  input  logic xfer,
  input  logic beat_wr,
  input  logic in_pktend,
  output logic commit_req
);
  localparam int BCW = $clog2(PKT_BYTES);
  localparam int ICW = $clog2(IDLE_TIMEOUT + 1);

  logic [BCW-1:0] byte_cnt;
  logic [ICW-1:0] idle_cnt;
  logic           idle_inc;

  assign idle_inc   = in_idle & !xfer & (byte_cnt != '0);
  // A transfer in the timeout cycle suppresses the commit.
  assign commit_req = idle_inc & (idle_cnt == ICW'(IDLE_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || in_pktend) begin
      byte_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      if (beat_wr) byte_cnt <= byte_cnt + BCW'(FD_WIDTH / 8);
      if (xfer || beat_wr) idle_cnt <= '0;
      else if (idle_inc)   idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fx2lp_stream_tx.sv
// Serialises IN_BYTES-wide stream words little-endian onto the FX2LP FD bus, stalling on flagb_n.
// One cycle accept-to-strobe, gapless back-to-back; FX2LP_SHORT_PKT_EN adds idle-timeout PKTEND.
module fx2lp_stream_tx
  import fx2lp_pkg::*;
#(
  parameter int         IN_BYTES     = 4,
  parameter int         FD_WIDTH     = 8,
  parameter logic [1:0] FIFOADR      = 2'b00,
  parameter int         PKT_BYTES    = 512,
  parameter int         IDLE_TIMEOUT = 1024
) (
  input logic              csi_clk,
  input logic              rsi_reset,
  fx2lp_stream_tx_if.slave bus
);
  localparam int DW    = 8 * IN_BYTES;
  localparam int BEATS = beats(IN_BYTES, FD_WIDTH);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (!(FD_WIDTH == 8 || FD_WIDTH == 16) || (DW % FD_WIDTH) != 0) begin : g_bad_width
    $error("fx2lp_stream_tx: illegal IN_BYTES/FD_WIDTH combination");
  end
  if (PKT_BYTES < 2 || (PKT_BYTES & (PKT_BYTES - 1)) != 0 || (PKT_BYTES % (FD_WIDTH / 8)) != 0) begin : g_bad_pkt
    $error("fx2lp_stream_tx: PKT_BYTES must be a power of two and whole beats");
  end
  if (IDLE_TIMEOUT < 1) begin : g_bad_timeout
    $error("fx2lp_stream_tx: IDLE_TIMEOUT must be at least 1");
  end

  state_t              state, state_n;
  logic [BW-1:0]       b, b_n, b_inc;
  logic [DW-1:0]       data, data_n;
  logic [FD_WIDTH-1:0] fd, fd_n;
  logic                last, beat_wr, ready, xfer, commit_req;

  assign last    = (b == BW'(BEATS - 1));
  assign beat_wr = (state == WRITE) & bus.coe_fx2lp_flagb_n;
  assign ready   = bus.coe_fx2lp_flagb_n & !rsi_reset &
                   ((state == IDLE) | ((state == WRITE) & last));
  assign xfer    = bus.asi_in0_valid & ready;
  assign b_inc   = b + 1'b1;

  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      state <= IDLE;
      b     <= '0;
      data  <= '0;
      fd    <= '0;
    end else begin
      state <= state_n;
      b     <= b_n;
      data  <= data_n;
      fd    <= fd_n;
    end
  end

  always_comb begin
    state_n = state;
    b_n     = b;
    data_n  = data;
    fd_n    = fd;
    case (state)
      IDLE: begin
        if (xfer) begin
          state_n = WRITE;
          b_n     = '0;
          data_n  = bus.asi_in0_data;
          fd_n    = bus.asi_in0_data[FD_WIDTH-1:0];
        end else if (commit_req) begin
          state_n = PKTEND;
        end
      end
      WRITE: begin
        if (beat_wr) begin
          if (!last) begin
            b_n  = b_inc;
            fd_n = data[int'(b_inc)*FD_WIDTH +: FD_WIDTH];
          end else if (xfer) begin
            b_n    = '0;
            data_n = bus.asi_in0_data;
            fd_n   = bus.asi_in0_data[FD_WIDTH-1:0];
          end else begin
            // FD keeps the last beat; only the strobe drops.
            state_n = IDLE;
            b_n     = '0;
          end
        end
      end
      PKTEND:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

`ifdef FX2LP_SHORT_PKT_EN
  fx2lp_pkt_timer #(
    .FD_WIDTH    (FD_WIDTH),
    .PKT_BYTES   (PKT_BYTES),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) u_pkt_timer (
    .clk       (csi_clk),
    .rst       (rsi_reset),
    .in_idle   (state == IDLE),
    .xfer      (xfer),
    .beat_wr   (beat_wr),
    .in_pktend (state == PKTEND),
    .commit_req(commit_req)
  );
  assign bus.coe_fx2lp_pktend_n = !(state == PKTEND);
`else
  assign commit_req             = 1'b0;
  assign bus.coe_fx2lp_pktend_n = 1'b1;
`endif

  assign bus.asi_in0_ready     = ready;
  assign bus.coe_fx2lp_fd      = fd;
  assign bus.coe_fx2lp_slwr_n  = !beat_wr;
  assign bus.coe_fx2lp_slrd_n  = 1'b1;
  assign bus.coe_fx2lp_sloe_n  = 1'b1;
  assign bus.coe_fx2lp_fifoadr = FIFOADR;

endmodule

// File: tb/tb_fx2lp_stream_tx.sv
// Directed bench for fx2lp_stream_tx: an 8-bit and a 16-bit FD instance on one clock.
module tb_fx2lp_stream_tx;
  import fx2lp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fx2lp_stream_tx_if #(.IN_BYTES(4), .FD_WIDTH(8))  if8 ();
  fx2lp_stream_tx_if #(.IN_BYTES(4), .FD_WIDTH(16)) if16 ();

  fx2lp_stream_tx #(
    .IN_BYTES(4), .FD_WIDTH(8), .FIFOADR(EP6), .PKT_BYTES(512), .IDLE_TIMEOUT(16)
  ) dut8 (.csi_clk(clk), .rsi_reset(rst), .bus(if8));

  fx2lp_stream_tx #(
    .IN_BYTES(4), .FD_WIDTH(16), .FIFOADR(EP2), .PKT_BYTES(512), .IDLE_TIMEOUT(16)
  ) dut16 (.csi_clk(clk), .rsi_reset(rst), .bus(if16));

`ifdef FX2LP_SHORT_PKT_EN
  localparam logic PK_EN = 1'b1;
`else
  localparam logic PK_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive the 8-bit instance for one cycle; outputs are settled 1ns after the falling edge.
  task automatic cyc(input logic r, input logic v, input logic [31:0] d, input logic fb);
    @(negedge clk);
    rst                   = r;
    if8.asi_in0_valid     = v;
    if8.asi_in0_data      = d;
    if8.coe_fx2lp_flagb_n = fb;
    #1;
  endtask

  task automatic cyc16(input logic v, input logic [31:0] d);
    @(negedge clk);
    rst                    = 1'b0;
    if16.asi_in0_valid     = v;
    if16.asi_in0_data      = d;
    if16.coe_fx2lp_flagb_n = 1'b1;
    #1;
  endtask

  logic [7:0]  stall_fb  [7] = '{1, 0, 0, 0, 1, 1, 1};
  logic [7:0]  stall_fd  [7] = '{8'hA0, 8'hA1, 8'hA1, 8'hA1, 8'hA1, 8'hA2, 8'hA3};
  logic [7:0]  stall_slw [7] = '{0, 1, 1, 1, 0, 0, 0};
  logic [31:0] wa, wb, w;
  int          strobes, lows, bad;

  initial begin
    if8.asi_in0_valid = 1'b0;  if8.asi_in0_data = '0;  if8.coe_fx2lp_flagb_n = 1'b1;
    if16.asi_in0_valid = 1'b0; if16.asi_in0_data = '0; if16.coe_fx2lp_flagb_n = 1'b1;

    // Reset state
    cyc(1, 1, 32'h0, 1);
    cyc(1, 1, 32'h0, 1);
    chk("rst_ready",   if8.asi_in0_ready,     0);
    chk("rst_slwr",    if8.coe_fx2lp_slwr_n,  1);
    chk("rst_pktend",  if8.coe_fx2lp_pktend_n, 1);
    chk("rst_fd",      if8.coe_fx2lp_fd,      0);
    chk("rst_slrd",    if8.coe_fx2lp_slrd_n,  1);
    chk("rst_sloe",    if8.coe_fx2lp_sloe_n,  1);
    chk("rst_fifoadr", if8.coe_fx2lp_fifoadr, 2'b10);

    // Single word
    cyc(0, 1, 32'h44332211, 1);
    chk("w1_ready_idle", if8.asi_in0_ready, 1);
    chk("w1_slwr_idle",  if8.coe_fx2lp_slwr_n, 1);
    w = 32'h44332211;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 32'h0, 1);
      chk($sformatf("w1_fd%0d", i),    if8.coe_fx2lp_fd, w[8*i +: 8]);
      chk($sformatf("w1_slwr%0d", i),  if8.coe_fx2lp_slwr_n, 0);
      chk($sformatf("w1_ready%0d", i), if8.asi_in0_ready, (i == 3) ? 1 : 0);
    end
    cyc(0, 0, 32'h0, 1);
    chk("w1_slwr_after", if8.coe_fx2lp_slwr_n, 1);
    chk("w1_fd_hold",    if8.coe_fx2lp_fd, 8'h44);

    // Back-to-back words
    wa = 32'hA3A2A1A0;
    wb = 32'hB3B2B1B0;
    cyc(0, 1, wa, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(0, (i < 4), wb, 1);
      chk($sformatf("b2b_slwr%0d", i),  if8.coe_fx2lp_slwr_n, 0);
      chk($sformatf("b2b_fd%0d", i),    if8.coe_fx2lp_fd, (i < 4) ? wa[8*i +: 8] : wb[8*(i-4) +: 8]);
      chk($sformatf("b2b_ready%0d", i), if8.asi_in0_ready, (i == 3 || i == 7) ? 1 : 0);
    end
    cyc(0, 0, 32'h0, 1);
    chk("b2b_slwr_after", if8.coe_fx2lp_slwr_n, 1);

    // Full flag in IDLE blocks the accept; stall for 3 cycles on beat 1
    cyc(0, 1, wa, 0);
    chk("full_idle_ready", if8.asi_in0_ready, 0);
    cyc(0, 1, wa, 1);
    chk("full_idle_noxfer", if8.coe_fx2lp_slwr_n, 1);
    strobes = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 32'h0, stall_fb[i][0]);
      if (!if8.coe_fx2lp_slwr_n) strobes++;
      chk($sformatf("stall_slwr%0d", i), if8.coe_fx2lp_slwr_n, stall_slw[i]);
      chk($sformatf("stall_fd%0d", i),   if8.coe_fx2lp_fd, stall_fd[i]);
    end
    chk("stall_strobes", strobes, 4);
    cyc(0, 0, 32'h0, 1);
    chk("stall_slwr_after", if8.coe_fx2lp_slwr_n, 1);

    // Reset during beat 2
    cyc(0, 1, 32'h55667788, 1);
    cyc(0, 0, 32'h0, 1);
    cyc(0, 0, 32'h0, 1);
    cyc(1, 1, 32'h0, 1);
    chk("rmid_fd_beat2", if8.coe_fx2lp_fd, 8'h66);
    chk("rmid_ready",    if8.asi_in0_ready, 0);
    w = 32'h0D0C0B0A;
    cyc(0, 1, w, 1);
    chk("rmid_slwr_next", if8.coe_fx2lp_slwr_n, 1);
    chk("rmid_fd_next",   if8.coe_fx2lp_fd, 0);
    chk("rmid_ready_rel", if8.asi_in0_ready, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 32'h0, 1);
      chk($sformatf("rmid_fd%0d", i), if8.coe_fx2lp_fd, w[8*i +: 8]);
    end

    // Short packet: 3 words then idle
    cyc(1, 0, 32'h0, 1);
    cyc(0, 1, 32'h03020100, 1);
    for (int i = 0; i < 12; i++) begin
      cyc(0, (i < 8), (i < 4) ? 32'h07060504 : 32'h0B0A0908, 1);
      chk($sformatf("sp_fd%0d", i), if8.coe_fx2lp_fd, i);
    end
    lows = 0;
    for (int k = 1; k <= 16; k++) begin
      cyc(0, 0, 32'h0, 1);
      if (!if8.coe_fx2lp_pktend_n) lows++;
    end
    chk("sp_no_early_pktend", lows, 0);
    cyc(0, 0, 32'h0, 1);
    chk("sp_pktend",       if8.coe_fx2lp_pktend_n, !PK_EN);
    chk("sp_pktend_ready", if8.asi_in0_ready, !PK_EN);
    chk("sp_pktend_slwr",  if8.coe_fx2lp_slwr_n, 1);
    cyc(0, 0, 32'h0, 1);
    chk("sp_pktend_1cyc",  if8.coe_fx2lp_pktend_n, 1);
    chk("sp_ready_back",   if8.asi_in0_ready, 1);
    lows = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(0, 0, 32'h0, 1);
      if (!if8.coe_fx2lp_pktend_n) lows++;
    end
    chk("sp_no_pktend_at_zero", lows, 0);

    // Full packet of 128 words: auto-commit, no PKTEND
    cyc(0, 1, 32'h0, 1);
    strobes = 0;
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      w = {4{8'((i / 4) + 1)}};
      cyc(0, (i < 508), w, 1);
      if (!if8.coe_fx2lp_slwr_n) strobes++;
      if (if8.coe_fx2lp_fd !== 8'(i / 4)) bad++;
    end
    chk("full_strobes", strobes, 512);
    chk("full_data",    bad, 0);
    lows = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(0, 0, 32'h0, 1);
      if (!if8.coe_fx2lp_pktend_n) lows++;
    end
    chk("full_no_pktend", lows, 0);

    // Transfer on the timeout cycle wins over PKTEND
    cyc(0, 1, 32'h13121110, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 32'h0, 1);
    for (int k = 1; k <= 15; k++) cyc(0, 0, 32'h0, 1);
    cyc(0, 1, 32'h17161514, 1);
    chk("race_ready",  if8.asi_in0_ready, 1);
    chk("race_pktend", if8.coe_fx2lp_pktend_n, 1);
    cyc(0, 0, 32'h0, 1);
    chk("race_no_pktend", if8.coe_fx2lp_pktend_n, 1);
    chk("race_slwr",      if8.coe_fx2lp_slwr_n, 0);
    chk("race_fd",        if8.coe_fx2lp_fd, 8'h14);

    // 16-bit FD
    cyc16(1, 32'hDDCCBBAA);
    chk("fd16_ready_idle", if16.asi_in0_ready, 1);
    cyc16(0, 32'h0);
    chk("fd16_fd0",    if16.coe_fx2lp_fd, 16'hBBAA);
    chk("fd16_slwr0",  if16.coe_fx2lp_slwr_n, 0);
    chk("fd16_ready0", if16.asi_in0_ready, 0);
    cyc16(0, 32'h0);
    chk("fd16_fd1",    if16.coe_fx2lp_fd, 16'hDDCC);
    chk("fd16_slwr1",  if16.coe_fx2lp_slwr_n, 0);
    chk("fd16_ready1", if16.asi_in0_ready, 1);
    cyc16(0, 32'h0);
    chk("fd16_slwr_after", if16.coe_fx2lp_slwr_n, 1);
    chk("fd16_fifoadr",    if16.coe_fx2lp_fifoadr, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
